// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the decode stage scoreboard.
//   - Opcode constants: R-type, load, store, beq, bne.
//   - sb_entry_t: one scoreboard slot {valid, dest, is_load}; SB_ENTRY_W is its width.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int SB_ENTRY_W = 7;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb.sv
// hazard_sb: shift-register scoreboard of in-flight producers plus source compare.
// Ports:
//   clock      - state updates on the falling edge
//   reset_n    - synchronous active-low reset, empties every slot
//   push_i     - record shifted into slot 0 every edge (valid=0 when nothing issued)
//   req_i      - an instruction is being offered (hazards only exist when set)
//   rs_i/rt_i  - source registers of the offered instruction
//   use_rt_i   - rt is a real source (R-type, store, branch)
//   hazard_o   - combinational: offered instruction must wait
// Config: DECODE_FWD_EN restricts hazards to a load sitting in slot 0.
module hazard_sb
  import decode_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  sb_entry_t  push_i,
  input  logic       req_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rt_i,
  output logic       hazard_o
);

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];
  logic      hit_s;

  // Next scoreboard contents: new record at slot 0, everything else ages by one.
  always_comb begin
    sb_d[0] = push_i;
    for (int i = 1; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  // Scoreboard storage; the oldest slot simply falls off the end.
  always_ff @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  // Compare the offered sources against the pre-shift scoreboard; r0 never hazards.
  always_comb begin
    hit_s = 1'b0;
    if (req_i) begin
`ifdef DECODE_FWD_EN
      // ALU results are forwarded, only a load still in the newest slot blocks.
      if (sb_q[0].valid && sb_q[0].is_load && (sb_q[0].dest != 5'd0) &&
          ((sb_q[0].dest == rs_i) || (use_rt_i && (sb_q[0].dest == rt_i)))) begin
        hit_s = 1'b1;
      end else begin
        hit_s = 1'b0;
      end
`else
      for (int i = 0; i < DEPTH; i++) begin
        if (sb_q[i].valid && (sb_q[i].dest != 5'd0) &&
            ((sb_q[i].dest == rs_i) || (use_rt_i && (sb_q[i].dest == rt_i)))) begin
          hit_s = 1'b1;
        end
      end
`endif
    end else begin
      hit_s = 1'b0;
    end
  end

  assign hazard_o = hit_s;

endmodule

// File: rtl/decode_sb.sv
// decode_sb: instruction decode stage with a producer scoreboard interlock.
// Ports:
//   clock, reset_n        - falling-edge clock, synchronous active-low reset
//   ir, pc_in             - fetched instruction (bit 0 = MSB) and its pc
//   in_valid / in_ready   - fetch handshake (in_ready is combinational)
//   out_valid / out_ready - execute handshake (outputs registered)
//   pc_out, immed, op, fc, a_reg_add, b_reg_add, d_reg_add, d_we - decoded fields
//   stall_if   - !in_ready
//   stall_pipe - a bubble was inserted at the last edge
//   hazard_cnt - saturating count of bubble cycles
// Unused register fields are driven as 0 (b for I-type, d for store/branch).
// Config: DECODE_FWD_EN (see hazard_sb) selects load-use-only interlocking.
module decode_sb
  import decode_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [0:31]     ir,
  input  logic [0:XLEN-1] pc_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:XLEN-1] pc_out,
  output logic [0:XLEN-1] immed,
  output logic [0:5]      op,
  output logic [0:5]      fc,
  output logic [0:4]      a_reg_add,
  output logic [0:4]      b_reg_add,
  output logic [0:4]      d_reg_add,
  output logic            d_we,
  output logic            stall_if,
  output logic            stall_pipe,
  output logic [15:0]     hazard_cnt
);

  logic [5:0]      op_s;
  logic [4:0]      rs_s, rt_s, rd_s, dest_s;
  logic            use_rt_s, we_s, hazard_s, can_take_s, in_ready_s, accept_s;
  sb_entry_t       push_s;

  logic            out_valid_q, out_valid_d;
  logic            stall_q, stall_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [0:XLEN-1] pc_q, pc_d, imm_q, imm_d;
  logic [5:0]      op_q, op_d, fc_q, fc_d;
  logic [4:0]      a_q, a_d, b_q, b_d, d_q, d_d;
  logic            we_q, we_d;

  assign op_s = ir[0:5];
  assign rs_s = ir[6:10];
  assign rt_s = ir[11:15];
  assign rd_s = ir[16:20];

  // Instruction class: which operands are sources and where the result goes.
  always_comb begin
    case (op_s)
      OP_RTYPE: begin
        use_rt_s = 1'b1;
        dest_s   = rd_s;
        we_s     = 1'b1;
      end
      OP_STORE, OP_BEQ, OP_BNE: begin
        use_rt_s = 1'b1;
        dest_s   = 5'd0;
        we_s     = 1'b0;
      end
      default: begin
        use_rt_s = 1'b0;
        dest_s   = rt_s;
        we_s     = 1'b1;
      end
    endcase
  end

  assign can_take_s = !out_valid_q || out_ready;
  assign in_ready_s = !hazard_s && can_take_s;
  assign accept_s   = in_valid && in_ready_s;
  assign push_s     = {accept_s & we_s, dest_s, (op_s == OP_LOAD)};

  hazard_sb #(.DEPTH(DEPTH)) u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_i   (push_s),
    .req_i    (in_valid),
    .rs_i     (rs_s),
    .rt_i     (rt_s),
    .use_rt_i (use_rt_s),
    .hazard_o (hazard_s)
  );

  // Output register next state: load on accept, drop valid on drain, else hold.
  always_comb begin
    pc_d  = pc_q;
    imm_d = imm_q;
    op_d  = op_q;
    fc_d  = fc_q;
    a_d   = a_q;
    b_d   = b_q;
    d_d   = d_q;
    we_d  = we_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      pc_d        = pc_in;
      imm_d       = {{(XLEN-16){ir[16]}}, ir[16:31]};
      op_d        = op_s;
      fc_d        = ir[26:31];
      a_d         = rs_s;
      b_d         = use_rt_s ? rt_s : 5'd0;
      d_d         = dest_s;
      we_d        = we_s;
    end else if (can_take_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // A bubble only counts when downstream could have taken something.
    stall_d = hazard_s && can_take_s;
    if (stall_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(negedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      cnt_q       <= 16'd0;
      pc_q        <= '0;
      imm_q       <= '0;
      op_q        <= 6'd0;
      fc_q        <= 6'd0;
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      d_q         <= 5'd0;
      we_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      fc_q        <= fc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      we_q        <= we_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign stall_if   = !in_ready_s;
  assign out_valid  = out_valid_q;
  assign stall_pipe = stall_q;
  assign hazard_cnt = cnt_q;
  assign pc_out     = pc_q;
  assign immed      = imm_q;
  assign op         = op_q;
  assign fc         = fc_q;
  assign a_reg_add  = a_q;
  assign b_reg_add  = b_q;
  assign d_reg_add  = d_q;
  assign d_we       = we_q;

endmodule
